// File: rtl/area_hit_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : area_hit_counter_if
//  Description : Handshake bundle for area_hit_counter. Carries the upstream
//                dav_in_/rfd_in/z_in sample handshake and the downstream
//                dav_out_/rfd_out/count result handshake. The majority signal
//                exists only when AREA_HIT_COUNTER_MAJORITY_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface area_hit_counter_if #(
    parameter int CW = 5
);
    logic          dav_in_;
    logic          rfd_in;
    logic          z_in;
    logic          dav_out_;
    logic          rfd_out;
    logic [CW-1:0] count;
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
    logic          majority;
`endif

    // Environment side: drives samples upstream and acknowledges results.
    modport master (
        output dav_in_,
        output z_in,
        output rfd_out,
        input  rfd_in,
        input  dav_out_,
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
        input  majority,
`endif
        input  count
    );

    // Counter side.
    modport slave (
        input  dav_in_,
        input  z_in,
        input  rfd_out,
        output rfd_in,
        output dav_out_,
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
        output majority,
`endif
        output count
    );
endinterface
`default_nettype wire

// File: rtl/area_hit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : area_hit_counter
//  Description : Counts classification hits over a window of WINDOW samples
//                taken through a four-phase dav_/rfd handshake, then offers
//                the hit count downstream over the same protocol. Upstream is
//                back-pressured while the result is pending.
//                Optional macro AREA_HIT_COUNTER_MAJORITY_EN adds a registered
//                majority flag (2*hits > WINDOW).
//  Revision    : 1.0  initial release
// ============================================================================
module area_hit_counter #(
    parameter int WINDOW = 16,
    parameter int CW     = $clog2(WINDOW + 1)
) (
    input  wire logic         clock,
    input  wire logic         reset,
    area_hit_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IN_WAIT = 2'd0,
        IN_ACK  = 2'd1,
        OUT_DAV = 2'd2,
        OUT_REL = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_window = CW'(WINDOW);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_hits;
    logic [CW-1:0] w_hits_nxt;
    logic [CW-1:0] r_n;
    logic [CW-1:0] w_n_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_rfd_in;
    logic          w_rfd_in_nxt;
    logic          r_dav_out_;
    logic          w_dav_out_nxt;
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
    logic          r_majority;
    logic          w_majority_nxt;
`endif

    // Next-state and next-output decode; every output is a register, so this
    // block only computes the values loaded on the coming edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_hits_nxt    = r_hits;
        w_n_nxt       = r_n;
        w_count_nxt   = r_count;
        w_rfd_in_nxt  = r_rfd_in;
        w_dav_out_nxt = r_dav_out_;
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
        w_majority_nxt = r_majority;
`endif
        case (r_state)
            IN_WAIT: begin
                // z_in is only meaningful on the edge that takes the sample.
                if (!bus.dav_in_) begin
                    w_hits_nxt   = r_hits + CW'(bus.z_in);
                    w_n_nxt      = r_n + CW'(1);
                    w_rfd_in_nxt = 1'b0;
                    w_state_nxt  = IN_ACK;
                end
            end
            IN_ACK: begin
                if (bus.dav_in_) begin
                    if (r_n == c_window) begin
                        // Window complete: rfd_in stays low until the result
                        // has been taken downstream.
                        w_count_nxt   = r_hits;
                        w_dav_out_nxt = 1'b0;
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
                        w_majority_nxt = ({r_hits, 1'b0} > {1'b0, c_window});
`endif
                        w_state_nxt   = OUT_DAV;
                    end else begin
                        w_rfd_in_nxt = 1'b1;
                        w_state_nxt  = IN_WAIT;
                    end
                end
            end
            OUT_DAV: begin
                if (!bus.rfd_out) begin
                    w_dav_out_nxt = 1'b1;
                    w_state_nxt   = OUT_REL;
                end
            end
            OUT_REL: begin
                if (bus.rfd_out) begin
                    w_hits_nxt   = '0;
                    w_n_nxt      = '0;
                    w_rfd_in_nxt = 1'b1;
                    w_state_nxt  = IN_WAIT;
                end
            end
            default: begin
                w_state_nxt = IN_WAIT;
            end
        endcase
    end

    // State and output registers; reset abandons any partial window.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IN_WAIT;
            r_hits     <= '0;
            r_n        <= '0;
            r_count    <= '0;
            r_rfd_in   <= 1'b1;
            r_dav_out_ <= 1'b1;
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
            r_majority <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_hits     <= w_hits_nxt;
            r_n        <= w_n_nxt;
            r_count    <= w_count_nxt;
            r_rfd_in   <= w_rfd_in_nxt;
            r_dav_out_ <= w_dav_out_nxt;
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
            r_majority <= w_majority_nxt;
`endif
        end
    end

    assign bus.rfd_in   = r_rfd_in;
    assign bus.dav_out_ = r_dav_out_;
    assign bus.count    = r_count;
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
    assign bus.majority = r_majority;
`endif

endmodule
`default_nettype wire

// File: tb/tb_area_hit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_area_hit_counter
//  Description : Self-checking bench for area_hit_counter with WINDOW=4.
//                Table of windows plus hand-written back-pressure and reset
//                sequences; expected results flow through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_area_hit_counter;

    localparam int WINDOW = 4;
    localparam int CW     = 3;

    typedef struct {
        logic [WINDOW-1:0] z;          // z[0] is the first sample
        logic [CW-1:0]     exp_count;
        logic              exp_maj;
    } vec_t;

    typedef struct {
        logic [CW-1:0] count;
        logic          maj;
    } result_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    result_t sb[$];
    vec_t    tbl[6];

    area_hit_counter_if #(.CW(CW)) bus ();

    area_hit_counter #(.WINDOW(WINDOW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bounded wait for rfd_in to reach a level; an expired bound is a failure.
    task automatic wait_rfd_in(input logic val);
        int k;
        k = 0;
        while (bus.rfd_in !== val && k < 16) begin
            tick();
            k++;
        end
        check("rfd_in_wait", bus.rfd_in, val);
    endtask

    // One four-phase upstream transfer; z_in is scrambled outside the sample edge.
    task automatic send_sample(input logic z);
        wait_rfd_in(1'b1);
        bus.dav_in_ = 1'b0;
        bus.z_in    = z;
        tick();
        check("rfd_in_fall", bus.rfd_in, 1'b0);
        bus.dav_in_ = 1'b1;
        bus.z_in    = ~z;
        tick();
    endtask

    task automatic send_window(input logic [WINDOW-1:0] z, input logic [CW-1:0] c, input logic m);
        result_t r;
        for (int i = 0; i < WINDOW; i++) begin
            if (i == WINDOW - 1)
                check("dav_out_early", bus.dav_out_, 1'b1);
            send_sample(z[i]);
        end
        r.count = c;
        r.maj   = m;
        sb.push_back(r);
        check("dav_out_fall", bus.dav_out_, 1'b0);
        check("rfd_in_held", bus.rfd_in, 1'b0);
    endtask

    // Downstream acceptance of one result; compares against the scoreboard.
    task automatic receive_window();
        result_t r;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        r = sb.pop_front();
        check("count", bus.count, r.count);
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
        check("majority", bus.majority, r.maj);
`endif
        bus.rfd_out = 1'b0;
        tick();
        check("dav_out_release", bus.dav_out_, 1'b1);
        check("rfd_in_during_rel", bus.rfd_in, 1'b0);
        bus.rfd_out = 1'b1;
        tick();
        check("rfd_in_reopen", bus.rfd_in, 1'b1);
        check("count_hold", bus.count, r.count);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{z: 4'b1101, exp_count: 3'd3, exp_maj: 1'b1}; // 1,0,1,1
        tbl[1] = '{z: 4'b0000, exp_count: 3'd0, exp_maj: 1'b0};
        tbl[2] = '{z: 4'b1111, exp_count: 3'd4, exp_maj: 1'b1};
        tbl[3] = '{z: 4'b0011, exp_count: 3'd2, exp_maj: 1'b0}; // 1,1,0,0 tie
        tbl[4] = '{z: 4'b0010, exp_count: 3'd1, exp_maj: 1'b0}; // 0,1,0,0
        tbl[5] = '{z: 4'b1110, exp_count: 3'd3, exp_maj: 1'b1}; // 0,1,1,1

        bus.dav_in_ = 1'b1;
        bus.z_in    = 1'b0;
        bus.rfd_out = 1'b1;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_rfd_in", bus.rfd_in, 1'b1);
        check("reset_dav_out_", bus.dav_out_, 1'b1);
        check("reset_count", bus.count, 3'd0);
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
        check("reset_majority", bus.majority, 1'b0);
`endif

        // Table-driven windows with a prompt downstream.
        for (int v = 0; v < 6; v++) begin
            send_window(tbl[v].z, tbl[v].exp_count, tbl[v].exp_maj);
            receive_window();
        end

        // Downstream stalls 20 cycles; a held dav_in_=0 must not be sampled.
        send_window(4'b0111, 3'd3, 1'b1);
        bus.dav_in_ = 1'b0;
        bus.z_in    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("stall_rfd_in", bus.rfd_in, 1'b0);
            check("stall_dav_out_", bus.dav_out_, 1'b0);
            check("stall_count", bus.count, 3'd3);
        end
        bus.dav_in_ = 1'b1;
        tick();
        receive_window();
        send_window(4'b0000, 3'd0, 1'b0);
        receive_window();

        // Reset mid-window abandons the two hits already taken.
        send_sample(1'b1);
        send_sample(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midwin_rst_rfd_in", bus.rfd_in, 1'b1);
        check("midwin_rst_count", bus.count, 3'd0);
        send_window(4'b1000, 3'd1, 1'b0);
        receive_window();

        // Reset while the result is being offered.
        send_window(4'b1111, 3'd4, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_front());
        check("outdav_rst_dav_out_", bus.dav_out_, 1'b1);
        check("outdav_rst_rfd_in", bus.rfd_in, 1'b1);
        check("outdav_rst_count", bus.count, 3'd0);
`ifdef AREA_HIT_COUNTER_MAJORITY_EN
        check("outdav_rst_majority", bus.majority, 1'b0);
`endif
        send_window(4'b0101, 3'd2, 1'b0);
        receive_window();

        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
